// File: rtl/ref_blk_cl_walker_pkg.sv
// Shared cache geometry, FSM encoding and payload types for the reference-block walker.
package ref_blk_cl_walker_pkg;

  localparam int unsigned X_ADDR_WDTH   = 12;
  localparam int unsigned Y_ADDR_WDTH   = 12;
  localparam int unsigned C_L_H_SIZE    = 3;
  localparam int unsigned C_L_V_SIZE    = 3;
  localparam int unsigned C_L_H_SIZE_C  = 2;
  localparam int unsigned C_L_V_SIZE_C  = 2;
  localparam int unsigned REF_ADDR_WDTH = 4;
  localparam int unsigned LUMA_DIM_WDTH = 4;
  localparam int unsigned CHMA_DIM_WDTH = 3;

  localparam int unsigned X_LINE_W = X_ADDR_WDTH - C_L_H_SIZE;
  localparam int unsigned Y_LINE_W = Y_ADDR_WDTH - C_L_V_SIZE;
  localparam int unsigned IDX_W    = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WALK = 1'b1;

  // Request fields latched at acceptance and held for the whole walk.
  typedef struct packed {
    logic [REF_ADDR_WDTH-1:0] ref_idx;
    logic [X_ADDR_WDTH-1:0]   start_x;
    logic [Y_ADDR_WDTH-1:0]   start_y;
    logic [X_ADDR_WDTH-2:0]   start_x_ch;
    logic [Y_ADDR_WDTH-2:0]   start_y_ch;
    logic [LUMA_DIM_WDTH-1:0] wdt;
    logic [LUMA_DIM_WDTH-1:0] hgt;
    logic [CHMA_DIM_WDTH-1:0] wdt_ch;
    logic [CHMA_DIM_WDTH-1:0] hgt_ch;
  } ref_req_t;

  // Per-component and combined cache-line deltas of one request.
  typedef struct packed {
    logic [IDX_W-1:0] x_luma;
    logic [IDX_W-1:0] y_luma;
    logic [IDX_W-1:0] x_chma;
    logic [IDX_W-1:0] y_chma;
    logic [IDX_W-1:0] x;
    logic [IDX_W-1:0] y;
  } delta_set_t;

  function automatic logic [IDX_W-1:0] idx_max(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [IDX_W-1:0] idx_min(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ref_blk_cl_walker_delta_calc.sv
// Number of extra cache lines a footprint spans along one axis.
module ref_blk_delta_calc
  import ref_blk_cl_walker_pkg::*;
#(
  parameter int unsigned LOW_W = 3,
  parameter int unsigned DIM_W = 4
) (
  input  logic [LOW_W-1:0] start_low,
  input  logic [DIM_W-1:0] extent,
  output logic [IDX_W-1:0] delta_c
);

  localparam int unsigned SUM_W = ((LOW_W > DIM_W) ? LOW_W : DIM_W) + 1;

  logic [SUM_W-1:0] sum_c;

  // Offset inside the first line plus extent, then whole lines past the first.
  always_comb begin
    sum_c   = SUM_W'(start_low) + SUM_W'(extent);
    delta_c = IDX_W'(sum_c >> LOW_W);
  end

endmodule

// File: rtl/ref_blk_cl_walker.sv
// Walks every luma/chroma cache line touched by one reference block, one beat per line.
module ref_blk_cl_walker
  import ref_blk_cl_walker_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [REF_ADDR_WDTH-1:0] ref_idx_in,
  input  logic [X_ADDR_WDTH-1:0]   start_x_in,
  input  logic [Y_ADDR_WDTH-1:0]   start_y_in,
  input  logic [X_ADDR_WDTH-2:0]   start_x_ch,
  input  logic [Y_ADDR_WDTH-2:0]   start_y_ch,
  input  logic [LUMA_DIM_WDTH-1:0] rf_blk_wdt_in,
  input  logic [LUMA_DIM_WDTH-1:0] rf_blk_hgt_in,
  input  logic [CHMA_DIM_WDTH-1:0] rf_blk_wdt_ch,
  input  logic [CHMA_DIM_WDTH-1:0] rf_blk_hgt_ch,
  output logic                     set_input_stage_valid,
  input  logic                     tag_compare_stage_ready_d,
  output logic                     last_block_valid_0d,
  output logic [X_LINE_W-1:0]      curr_x_addr,
  output logic [Y_LINE_W-1:0]      curr_y_addr,
  output logic [IDX_W-1:0]         curr_x,
  output logic [IDX_W-1:0]         curr_y,
  output logic [IDX_W-1:0]         delta_x,
  output logic [IDX_W-1:0]         delta_y,
  output logic [IDX_W-1:0]         curr_x_luma,
  output logic [IDX_W-1:0]         curr_y_luma,
  output logic [IDX_W-1:0]         curr_x_chma,
  output logic [IDX_W-1:0]         curr_y_chma,
  output logic [IDX_W-1:0]         delta_x_luma,
  output logic [IDX_W-1:0]         delta_y_luma,
  output logic [IDX_W-1:0]         delta_x_chma,
  output logic [IDX_W-1:0]         delta_y_chma,
  output logic                     cur_xy_changed_luma,
  output logic                     cur_xy_changed_chma,
  output logic [REF_ADDR_WDTH-1:0] ref_idx_out,
  output logic [X_ADDR_WDTH-1:0]   start_x_out,
  output logic [Y_ADDR_WDTH-1:0]   start_y_out,
  output logic [X_ADDR_WDTH-2:0]   start_x_ch_out,
  output logic [Y_ADDR_WDTH-2:0]   start_y_ch_out,
  output logic [LUMA_DIM_WDTH-1:0] rf_blk_wdt_out,
  output logic [LUMA_DIM_WDTH-1:0] rf_blk_hgt_out,
  output logic [CHMA_DIM_WDTH-1:0] rf_blk_wdt_ch_out,
  output logic [CHMA_DIM_WDTH-1:0] rf_blk_hgt_ch_out
);

  logic [0:0]          state_q, state_d;
  ref_req_t            req_q, req_d, req_in_c;
  delta_set_t          dlt_q, dlt_d, dlt_new_c;
  logic [IDX_W-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [X_LINE_W-1:0] addr_x_q, addr_x_d;
  logic [Y_LINE_W-1:0] addr_y_q, addr_y_d;
  logic [IDX_W-1:0]    cxl_q, cxl_d, cyl_q, cyl_d, cxc_q, cxc_d, cyc_q, cyc_d;
  logic                chg_l_q, chg_l_d, chg_c_q, chg_c_d;
  logic [IDX_W-1:0]    dxl_new_c, dyl_new_c, dxc_new_c, dyc_new_c;
  logic                consume_c, accept_c, load_c;

  // Per-axis deltas of the incoming request.
  ref_blk_delta_calc #(.LOW_W(C_L_H_SIZE), .DIM_W(LUMA_DIM_WDTH)) u_dx_luma (
    .start_low (start_x_in[C_L_H_SIZE-1:0]),
    .extent    (rf_blk_wdt_in),
    .delta_c   (dxl_new_c)
  );

  ref_blk_delta_calc #(.LOW_W(C_L_V_SIZE), .DIM_W(LUMA_DIM_WDTH)) u_dy_luma (
    .start_low (start_y_in[C_L_V_SIZE-1:0]),
    .extent    (rf_blk_hgt_in),
    .delta_c   (dyl_new_c)
  );

  ref_blk_delta_calc #(.LOW_W(C_L_H_SIZE_C), .DIM_W(CHMA_DIM_WDTH)) u_dx_chma (
    .start_low (start_x_ch[C_L_H_SIZE_C-1:0]),
    .extent    (rf_blk_wdt_ch),
    .delta_c   (dxc_new_c)
  );

  ref_blk_delta_calc #(.LOW_W(C_L_V_SIZE_C), .DIM_W(CHMA_DIM_WDTH)) u_dy_chma (
    .start_low (start_y_ch[C_L_V_SIZE_C-1:0]),
    .extent    (rf_blk_hgt_ch),
    .delta_c   (dyc_new_c)
  );

  // Incoming request payload and its combined deltas.
  always_comb begin
    req_in_c.ref_idx    = ref_idx_in;
    req_in_c.start_x    = start_x_in;
    req_in_c.start_y    = start_y_in;
    req_in_c.start_x_ch = start_x_ch;
    req_in_c.start_y_ch = start_y_ch;
    req_in_c.wdt        = rf_blk_wdt_in;
    req_in_c.hgt        = rf_blk_hgt_in;
    req_in_c.wdt_ch     = rf_blk_wdt_ch;
    req_in_c.hgt_ch     = rf_blk_hgt_ch;
    dlt_new_c.x_luma    = dxl_new_c;
    dlt_new_c.y_luma    = dyl_new_c;
    dlt_new_c.x_chma    = dxc_new_c;
    dlt_new_c.y_chma    = dyc_new_c;
    dlt_new_c.x         = idx_max(dxl_new_c, dxc_new_c);
    dlt_new_c.y         = idx_max(dyl_new_c, dyc_new_c);
  end

  // Handshakes: a new request is taken when idle or while the final beat drains.
  always_comb begin
    consume_c = valid_q & tag_compare_stage_ready_d;
    req_ready = (state_q == ST_IDLE) | (consume_c & last_q);
    accept_c  = req_valid & req_ready;
  end

  // Next state, raster advance and the beat fields derived from the next indices.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    dlt_d   = dlt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    load_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) load_c = 1'b1;
      end
      ST_WALK: begin
        if (consume_c) begin
          if (last_q) begin
            if (accept_c) load_c = 1'b1;
            else          state_d = ST_IDLE;
          end else if (cx_q < dlt_q.x) begin
            cx_d = cx_q + IDX_W'(1);
          end else begin
            cx_d = '0;
            cy_d = cy_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_c) begin
      state_d = ST_WALK;
      req_d   = req_in_c;
      dlt_d   = dlt_new_c;
      cx_d    = '0;
      cy_d    = '0;
    end

    valid_d  = (state_d == ST_WALK);
    last_d   = valid_d && (cx_d == dlt_d.x) && (cy_d == dlt_d.y);
    addr_x_d = X_LINE_W'(req_d.start_x[X_ADDR_WDTH-1:C_L_H_SIZE] + X_LINE_W'(cx_d));
    addr_y_d = Y_LINE_W'(req_d.start_y[Y_ADDR_WDTH-1:C_L_V_SIZE] + Y_LINE_W'(cy_d));
    cxl_d    = idx_min(cx_d, dlt_d.x_luma);
    cyl_d    = idx_min(cy_d, dlt_d.y_luma);
    cxc_d    = idx_min(cx_d, dlt_d.x_chma);
    cyc_d    = idx_min(cy_d, dlt_d.y_chma);
    chg_l_d  = (cx_d <= dlt_d.x_luma) && (cy_d <= dlt_d.y_luma);
    chg_c_d  = (cx_d <= dlt_d.x_chma) && (cy_d <= dlt_d.y_chma);
  end

  // State and beat registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      dlt_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      addr_x_q <= '0;
      addr_y_q <= '0;
      cxl_q    <= '0;
      cyl_q    <= '0;
      cxc_q    <= '0;
      cyc_q    <= '0;
      chg_l_q  <= 1'b0;
      chg_c_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      dlt_q    <= dlt_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      addr_x_q <= addr_x_d;
      addr_y_q <= addr_y_d;
      cxl_q    <= cxl_d;
      cyl_q    <= cyl_d;
      cxc_q    <= cxc_d;
      cyc_q    <= cyc_d;
      chg_l_q  <= chg_l_d;
      chg_c_q  <= chg_c_d;
    end
  end

  // Output mapping of the registered beat and latched request.
  always_comb begin
    set_input_stage_valid = valid_q;
    last_block_valid_0d   = last_q;
    curr_x_addr           = addr_x_q;
    curr_y_addr           = addr_y_q;
    curr_x                = cx_q;
    curr_y                = cy_q;
    delta_x               = dlt_q.x;
    delta_y               = dlt_q.y;
    curr_x_luma           = cxl_q;
    curr_y_luma           = cyl_q;
    curr_x_chma           = cxc_q;
    curr_y_chma           = cyc_q;
    delta_x_luma          = dlt_q.x_luma;
    delta_y_luma          = dlt_q.y_luma;
    delta_x_chma          = dlt_q.x_chma;
    delta_y_chma          = dlt_q.y_chma;
    cur_xy_changed_luma   = chg_l_q;
    cur_xy_changed_chma   = chg_c_q;
    ref_idx_out           = req_q.ref_idx;
    start_x_out           = req_q.start_x;
    start_y_out           = req_q.start_y;
    start_x_ch_out        = req_q.start_x_ch;
    start_y_ch_out        = req_q.start_y_ch;
    rf_blk_wdt_out        = req_q.wdt;
    rf_blk_hgt_out        = req_q.hgt;
    rf_blk_wdt_ch_out     = req_q.wdt_ch;
    rf_blk_hgt_ch_out     = req_q.hgt_ch;
  end

endmodule

// File: tb/tb_ref_blk_cl_walker.sv
// Randomized bench for the cache-line walker against a beat-list reference model.
module tb_ref_blk_cl_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  ref_idx_in;
  logic [11:0] start_x_in, start_y_in;
  logic [10:0] start_x_ch, start_y_ch;
  logic [3:0]  rf_blk_wdt_in, rf_blk_hgt_in;
  logic [2:0]  rf_blk_wdt_ch, rf_blk_hgt_ch;
  logic        set_input_stage_valid;
  logic        tag_compare_stage_ready_d;
  logic        last_block_valid_0d;
  logic [8:0]  curr_x_addr, curr_y_addr;
  logic [1:0]  curr_x, curr_y, delta_x, delta_y;
  logic [1:0]  curr_x_luma, curr_y_luma, curr_x_chma, curr_y_chma;
  logic [1:0]  delta_x_luma, delta_y_luma, delta_x_chma, delta_y_chma;
  logic        cur_xy_changed_luma, cur_xy_changed_chma;
  logic [3:0]  ref_idx_out;
  logic [11:0] start_x_out, start_y_out;
  logic [10:0] start_x_ch_out, start_y_ch_out;
  logic [3:0]  rf_blk_wdt_out, rf_blk_hgt_out;
  logic [2:0]  rf_blk_wdt_ch_out, rf_blk_hgt_ch_out;

  always #5 clk = ~clk;

  ref_blk_cl_walker dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .ref_idx_in(ref_idx_in), .start_x_in(start_x_in), .start_y_in(start_y_in),
    .start_x_ch(start_x_ch), .start_y_ch(start_y_ch),
    .rf_blk_wdt_in(rf_blk_wdt_in), .rf_blk_hgt_in(rf_blk_hgt_in),
    .rf_blk_wdt_ch(rf_blk_wdt_ch), .rf_blk_hgt_ch(rf_blk_hgt_ch),
    .set_input_stage_valid(set_input_stage_valid),
    .tag_compare_stage_ready_d(tag_compare_stage_ready_d),
    .last_block_valid_0d(last_block_valid_0d),
    .curr_x_addr(curr_x_addr), .curr_y_addr(curr_y_addr),
    .curr_x(curr_x), .curr_y(curr_y), .delta_x(delta_x), .delta_y(delta_y),
    .curr_x_luma(curr_x_luma), .curr_y_luma(curr_y_luma),
    .curr_x_chma(curr_x_chma), .curr_y_chma(curr_y_chma),
    .delta_x_luma(delta_x_luma), .delta_y_luma(delta_y_luma),
    .delta_x_chma(delta_x_chma), .delta_y_chma(delta_y_chma),
    .cur_xy_changed_luma(cur_xy_changed_luma), .cur_xy_changed_chma(cur_xy_changed_chma),
    .ref_idx_out(ref_idx_out), .start_x_out(start_x_out), .start_y_out(start_y_out),
    .start_x_ch_out(start_x_ch_out), .start_y_ch_out(start_y_ch_out),
    .rf_blk_wdt_out(rf_blk_wdt_out), .rf_blk_hgt_out(rf_blk_hgt_out),
    .rf_blk_wdt_ch_out(rf_blk_wdt_ch_out), .rf_blk_hgt_ch_out(rf_blk_hgt_ch_out)
  );

  typedef struct {
    int ref_idx, sx, sy, sxc, syc, w, h, wc, hc;
  } tb_req_t;

  typedef struct {
    tb_req_t r;
    int cx, cy, dx, dy, dxl, dyl, dxc, dyc;
    int cxl, cyl, cxc, cyc, ax, ay, chl, chc, last;
  } exp_beat_t;

  exp_beat_t exp_q[$];
  tb_req_t   req_list[$];
  bit        rdy_pat[$];
  tb_req_t   pend;
  bit        pend_valid;
  int        n_checks;
  int        n_errors;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: the footprint spans (delta+1) lines per axis; beats in raster order.
  task automatic push_beats(input tb_req_t r);
    exp_beat_t b;
    b.r   = r;
    b.dxl = ((r.sx % 8) + r.w) / 8;
    b.dyl = ((r.sy % 8) + r.h) / 8;
    b.dxc = ((r.sxc % 4) + r.wc) / 4;
    b.dyc = ((r.syc % 4) + r.hc) / 4;
    b.dx  = imax(b.dxl, b.dxc);
    b.dy  = imax(b.dyl, b.dyc);
    for (int y = 0; y <= b.dy; y++) begin
      for (int x = 0; x <= b.dx; x++) begin
        b.cx   = x;
        b.cy   = y;
        b.cxl  = imin(x, b.dxl);
        b.cyl  = imin(y, b.dyl);
        b.cxc  = imin(x, b.dxc);
        b.cyc  = imin(y, b.dyc);
        b.ax   = ((r.sx / 8) + x) % 512;
        b.ay   = ((r.sy / 8) + y) % 512;
        b.chl  = (x <= b.dxl && y <= b.dyl) ? 1 : 0;
        b.chc  = (x <= b.dxc && y <= b.dyc) ? 1 : 0;
        b.last = (x == b.dx && y == b.dy) ? 1 : 0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic check_beat(input exp_beat_t b);
    check_val("curr_x", curr_x, b.cx);
    check_val("curr_y", curr_y, b.cy);
    check_val("delta_x", delta_x, b.dx);
    check_val("delta_y", delta_y, b.dy);
    check_val("delta_x_luma", delta_x_luma, b.dxl);
    check_val("delta_y_luma", delta_y_luma, b.dyl);
    check_val("delta_x_chma", delta_x_chma, b.dxc);
    check_val("delta_y_chma", delta_y_chma, b.dyc);
    check_val("curr_x_luma", curr_x_luma, b.cxl);
    check_val("curr_y_luma", curr_y_luma, b.cyl);
    check_val("curr_x_chma", curr_x_chma, b.cxc);
    check_val("curr_y_chma", curr_y_chma, b.cyc);
    check_val("curr_x_addr", curr_x_addr, b.ax);
    check_val("curr_y_addr", curr_y_addr, b.ay);
    check_val("changed_luma", cur_xy_changed_luma, b.chl);
    check_val("changed_chma", cur_xy_changed_chma, b.chc);
    check_val("last", last_block_valid_0d, b.last);
    check_val("ref_idx_out", ref_idx_out, b.r.ref_idx);
    check_val("start_x_out", start_x_out, b.r.sx);
    check_val("start_y_out", start_y_out, b.r.sy);
    check_val("start_x_ch_out", start_x_ch_out, b.r.sxc);
    check_val("start_y_ch_out", start_y_ch_out, b.r.syc);
    check_val("wdt_out", rf_blk_wdt_out, b.r.w);
    check_val("hgt_out", rf_blk_hgt_out, b.r.h);
    check_val("wdt_ch_out", rf_blk_wdt_ch_out, b.r.wc);
    check_val("hgt_ch_out", rf_blk_hgt_ch_out, b.r.hc);
  endtask

  function automatic tb_req_t mk_req(input int sx, input int sy, input int w, input int h,
                                     input int sxc, input int syc, input int wc, input int hc);
    tb_req_t r;
    r.ref_idx = int'($urandom_range(0, 15));
    r.sx = sx; r.sy = sy; r.w = w; r.h = h;
    r.sxc = sxc; r.syc = syc; r.wc = wc; r.hc = hc;
    return r;
  endfunction

  function automatic tb_req_t rand_req();
    return mk_req(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
  endfunction

  // One clock: check the visible beat, drive the next inputs, update the model.
  task automatic step(input bit allow_gaps, input bit rand_ready);
    bit rdy;
    bit exp_rr;
    @(negedge clk);
    check_val("valid", set_input_stage_valid, (exp_q.size() != 0) ? 1 : 0);
    if (exp_q.size() != 0) check_beat(exp_q[0]);
    if (rdy_pat.size() != 0) rdy = rdy_pat.pop_front();
    else                     rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!pend_valid && req_list.size() != 0 && (!allow_gaps || $urandom_range(0, 3) != 0)) begin
      pend       = req_list.pop_front();
      pend_valid = 1'b1;
    end
    tag_compare_stage_ready_d = rdy;
    req_valid     = pend_valid;
    ref_idx_in    = 4'(pend.ref_idx);
    start_x_in    = 12'(pend.sx);
    start_y_in    = 12'(pend.sy);
    start_x_ch    = 11'(pend.sxc);
    start_y_ch    = 11'(pend.syc);
    rf_blk_wdt_in = 4'(pend.w);
    rf_blk_hgt_in = 4'(pend.h);
    rf_blk_wdt_ch = 3'(pend.wc);
    rf_blk_hgt_ch = 3'(pend.hc);
    #1;
    exp_rr = (exp_q.size() == 0) || (exp_q.size() == 1 && rdy);
    check_val("req_ready", req_ready, exp_rr);
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    if (pend_valid && exp_rr) begin
      push_beats(pend);
      pend_valid = 1'b0;
    end
  endtask

  task automatic run_list(input bit allow_gaps, input bit rand_ready);
    int cyc = 0;
    while ((req_list.size() != 0 || pend_valid || exp_q.size() != 0) && cyc < 20000) begin
      step(allow_gaps, rand_ready);
      cyc++;
    end
    check_val("drain", exp_q.size() + req_list.size() + int'(pend_valid), 0);
    step(1'b0, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_valid"}, set_input_stage_valid, 0);
    check_val({tag, "_req_ready"}, req_ready, 1);
    check_val({tag, "_last"}, last_block_valid_0d, 0);
    check_val({tag, "_curr_x"}, curr_x, 0);
    check_val({tag, "_curr_y"}, curr_y, 0);
    check_val({tag, "_x_addr"}, curr_x_addr, 0);
    check_val({tag, "_y_addr"}, curr_y_addr, 0);
    check_val({tag, "_delta_x"}, delta_x, 0);
    check_val({tag, "_delta_y"}, delta_y, 0);
    check_val({tag, "_start_x_out"}, start_x_out, 0);
    check_val({tag, "_ref_idx_out"}, ref_idx_out, 0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    pend_valid = 1'b0;
    pend       = mk_req(0, 0, 0, 0, 0, 0, 0, 0);
    reset      = 1'b1;
    req_valid  = 1'b0;
    tag_compare_stage_ready_d = 1'b1;
    ref_idx_in = '0; start_x_in = '0; start_y_in = '0; start_x_ch = '0; start_y_ch = '0;
    rf_blk_wdt_in = '0; rf_blk_hgt_in = '0; rf_blk_wdt_ch = '0; rf_blk_hgt_ch = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("rst");
    reset = 1'b0;

    // Two-line luma/chroma footprint, addresses 1 and 2.
    req_list.push_back(mk_req(13, 0, 6, 3, 6, 0, 3, 1));
    run_list(1'b0, 1'b0);
    // Chroma wider than luma: luma index saturates.
    req_list.push_back(mk_req(7, 0, 0, 0, 3, 0, 2, 0));
    run_list(1'b0, 1'b0);
    // 2x2 walk with downstream stalls.
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    req_list.push_back(mk_req(4, 4, 7, 7, 0, 0, 0, 0));
    run_list(1'b0, 1'b0);
    // Back-to-back requests, single-line block, and x address wrap.
    req_list.push_back(mk_req(4, 4, 7, 7, 0, 0, 0, 0));
    req_list.push_back(mk_req(0, 0, 0, 0, 0, 0, 0, 0));
    req_list.push_back(mk_req(12'hFFF, 8, 1, 0, 0, 0, 0, 0));
    run_list(1'b0, 1'b0);

    // Reset in the middle of a 4-beat walk.
    req_list.push_back(mk_req(4, 4, 7, 7, 0, 0, 0, 0));
    repeat (3) step(1'b0, 1'b0);
    check_val("mid_beat_x", curr_x, 1);
    reset = 1'b1;
    @(negedge clk);
    check_cleared("midrst");
    reset = 1'b0;
    exp_q.delete();

    // Random requests, random gaps and stalls.
    for (int i = 0; i < 150; i++) req_list.push_back(rand_req());
    run_list(1'b1, 1'b1);
    for (int i = 0; i < 60; i++) req_list.push_back(rand_req());
    run_list(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
